// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, SPI_SLV_CTRL field
// positions, SPI mode constants and word-length decode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam int unsigned CTRL_ON      = 6;
  localparam int unsigned CTRL_CPOL    = 5;
  localparam int unsigned CTRL_CPHA    = 4;
  localparam int unsigned CTRL_ORDER   = 3;
  localparam int unsigned CTRL_LEN_MSB = 2;
  localparam int unsigned CTRL_LEN_LSB = 1;
  localparam int unsigned CTRL_IMSK    = 0;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [5:0] len_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchroniser with a delay flop for rise/fall detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{i_rst_val}};
      r_dly  <= i_rst_val;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave_control.sv
// SPI responder control: synchronises SCK/SS/MOSI into clk_cpu, shifts words
// in from MOSI and out to MISO from a CPU-loaded transmit buffer.
module spi_slave_control
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic [6:0]            SPI_SLV_CTRL,
  input  logic                  SCK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] SPI_TX_DATA,
  input  logic                  tx_load,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] SPI_RX_DATA,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  overrun,
  output logic                  busy,
  output logic                  interrpt,
  input  logic                  int_clr
);

  localparam logic [6:0] DW7 = 7'(DATA_WIDTH);

  logic       w_on, w_cpol, w_cpha, w_lsb, w_imsk;
  logic [1:0] w_len;
  assign w_on   = SPI_SLV_CTRL[CTRL_ON];
  assign w_cpol = SPI_SLV_CTRL[CTRL_CPOL];
  assign w_cpha = SPI_SLV_CTRL[CTRL_CPHA];
  assign w_lsb  = SPI_SLV_CTRL[CTRL_ORDER];
  assign w_len  = SPI_SLV_CTRL[CTRL_LEN_MSB:CTRL_LEN_LSB];
  assign w_imsk = SPI_SLV_CTRL[CTRL_IMSK];

  logic w_sck_rise, w_sck_fall, w_ss_lvl, w_ss_rise, w_ss_fall, w_mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .i_clk(clk_cpu), .i_rst(rst), .i_rst_val(w_cpol), .i_d(SCK),
    .o_level(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .i_clk(clk_cpu), .i_rst(rst), .i_rst_val(1'b1), .i_d(SS),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .i_clk(clk_cpu), .i_rst(rst), .i_rst_val(1'b0), .i_d(MOSI),
    .o_level(w_mosi), .o_rise(), .o_fall()
  );

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_tx_buf, r_tx_sh, r_rx_sh, r_rx_data;
  logic                  r_tx_empty, r_miso, r_rx_valid, r_rx_full, r_overrun, r_irq;
  logic [5:0]            r_cnt, r_nbits;

  logic w_lead, w_trail, w_sample, w_drive;
  assign w_lead   = w_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail  = w_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample = w_on & (w_cpha ? w_trail : w_lead);
  // CPHA=0: the trailing edge left over from the previous word must not
  // advance a freshly reloaded shifter, hence the count guard.
  assign w_drive  = w_on & (r_state == SHIFT) &
                    (w_cpha ? w_lead : (w_trail & (r_cnt != 6'd0)));

  logic w_frame_start, w_load;
  assign w_frame_start = (r_state == IDLE) & w_on & w_ss_fall;
  assign w_load        = w_frame_start | ((r_state == COMPLETE) & w_on & ~w_ss_lvl);

  logic [5:0]            w_nbits_ld;
  logic [6:0]            w_tx_shamt, w_rx_shamt;
  logic [DATA_WIDTH-1:0] w_tx_src, w_tx_al, w_rx_word;
  logic                  w_rx_take;
  assign w_nbits_ld = w_frame_start ? len_bits(w_len) : r_nbits;
  assign w_tx_shamt = DW7 - {1'b0, w_nbits_ld};
  assign w_rx_shamt = DW7 - {1'b0, r_nbits};
  assign w_tx_src   = tx_load ? SPI_TX_DATA : (r_tx_empty ? '0 : r_tx_buf);
  assign w_tx_al    = w_lsb ? w_tx_src : (w_tx_src << w_tx_shamt);
  assign w_rx_word  = w_lsb ? (r_rx_sh >> w_rx_shamt) : r_rx_sh;
  assign w_rx_take  = ~r_rx_full | rx_ack;

  always_ff @(posedge clk_cpu) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_on) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_ss_fall) w_next = SHIFT;
        SHIFT: begin
          if (w_ss_rise)                                  w_next = IDLE;
          else if (w_sample && (r_cnt + 6'd1 == r_nbits)) w_next = COMPLETE;
        end
        COMPLETE: w_next = w_ss_lvl ? IDLE : SHIFT;
        default:  w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      r_tx_buf   <= '0;
      r_tx_empty <= 1'b1;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
      r_nbits    <= 6'd8;
      r_miso     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_full  <= 1'b0;
      r_overrun  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (tx_load) begin
        r_tx_buf   <= SPI_TX_DATA;
        r_tx_empty <= 1'b0;
      end
      if (rx_ack)  r_rx_full <= 1'b0;
      if (int_clr) begin
        r_irq     <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_frame_start) r_nbits <= len_bits(w_len);

      if (w_load) begin
        r_tx_empty <= 1'b1;
        r_cnt      <= '0;
        r_rx_sh    <= '0;
        if (w_cpha) begin
          r_tx_sh <= w_tx_al;
        end else begin
          r_miso  <= w_lsb ? w_tx_al[0] : w_tx_al[DATA_WIDTH-1];
          r_tx_sh <= w_lsb ? (w_tx_al >> 1) : (w_tx_al << 1);
        end
      end else if (r_state == SHIFT) begin
        if (w_ss_rise) begin
          r_miso <= 1'b0;
        end else begin
          if (w_sample) begin
            r_rx_sh <= w_lsb ? {w_mosi, r_rx_sh[DATA_WIDTH-1:1]}
                             : {r_rx_sh[DATA_WIDTH-2:0], w_mosi};
            r_cnt   <= r_cnt + 6'd1;
          end
          if (w_drive) begin
            r_miso  <= w_lsb ? r_tx_sh[0] : r_tx_sh[DATA_WIDTH-1];
            r_tx_sh <= w_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
          end
        end
      end else if (r_state == IDLE) begin
        r_miso <= 1'b0;
      end

      // Placed after the rx_ack/int_clr updates so a new set wins.
      if (r_state == COMPLETE) begin
        if (w_rx_take) begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
          r_rx_full  <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
        if (!w_imsk) r_irq <= 1'b1;
      end
    end
  end

  assign MISO        = r_miso & ~w_ss_lvl & w_on;
  assign tx_empty    = r_tx_empty;
  assign SPI_RX_DATA = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign overrun     = r_overrun;
  assign busy        = (r_state == SHIFT);
  assign interrpt    = r_irq;

endmodule

// File: tb/tb_spi_slave_control.sv
// Directed bench for spi_slave_control: acts as SPI master, checks received
// words, MISO data, status flags and reset behaviour.
module tb_spi_slave_control;
  import spi_pkg::*;

  localparam int unsigned H = 8;  // clk_cpu cycles per SCK half period

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  ctrl = '0;
  logic        sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic        miso;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0, rx_ack = 1'b0, int_clr = 1'b0;
  logic        tx_empty, rx_valid, overrun, busy, interrpt;
  logic [31:0] rx_data;

  int total = 0;
  int bad = 0;
  int vcnt = 0;

  spi_slave_control #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .SPI_SLV_CTRL(ctrl),
    .SCK(sck), .SS(ss), .MOSI(mosi), .MISO(miso),
    .SPI_TX_DATA(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .SPI_RX_DATA(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .busy(busy), .interrpt(interrpt), .int_clr(int_clr)
  );

  always #5 clk_cpu = ~clk_cpu;

  always @(negedge clk_cpu) if (rx_valid) vcnt <= vcnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk_cpu);
  endtask

  task automatic pulse_load(input logic [31:0] d);
    tx_data = d; tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic ack_clr();
    rx_ack = 1'b1; int_clr = 1'b1;
    wait_cyc(1);
    rx_ack = 1'b0; int_clr = 1'b0;
    wait_cyc(1);
  endtask

  task automatic set_ctrl(input logic [6:0] c);
    ctrl = c;
    sck  = c[CTRL_CPOL];
    wait_cyc(8);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    wait_cyc(4);
  endtask

  task automatic frame_end();
    wait_cyc(H);
    ss = 1'b1;
    mosi = 1'b0;
    wait_cyc(8);
  endtask

  // Clocks nclk bits of an nb-bit word; mi collects MISO at the master sample point.
  task automatic xfer_word(input int unsigned nb, input int unsigned nclk,
                           input logic [31:0] mo, output logic [31:0] mi);
    logic cpol, cpha, lsb;
    int unsigned b;
    cpol = ctrl[CTRL_CPOL]; cpha = ctrl[CTRL_CPHA]; lsb = ctrl[CTRL_ORDER];
    mi = '0;
    for (int unsigned i = 0; i < nclk; i++) begin
      b = lsb ? i : (nb - 1 - i);
      if (!cpha) begin
        mosi = mo[b];
        wait_cyc(H);
        sck = ~cpol;
        mi[b] = miso;
        wait_cyc(H);
        sck = cpol;
      end else begin
        wait_cyc(H);
        sck = ~cpol;
        mosi = mo[b];
        wait_cyc(H);
        sck = cpol;
        mi[b] = miso;
      end
    end
  endtask

  logic [31:0] mi1, mi2;
  int v0;

  initial begin
    wait_cyc(3);
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_tx_empty", {31'b0, tx_empty}, 32'h1);
    chk("rst_flags", {27'b0, miso, rx_valid, overrun, busy, interrpt}, 32'h0);
    rst = 1'b0;

    // Mode 0, 8-bit, MSB first
    set_ctrl({1'b1, MODE0, 1'b0, 2'b00, 1'b0});
    pulse_load(32'h3C);
    chk("t1_tx_loaded", {31'b0, tx_empty}, 32'h0);
    v0 = vcnt;
    frame_start();
    xfer_word(8, 8, 32'hA5, mi1);
    frame_end();
    chk("t1_rx_data", rx_data, 32'h0000_00A5);
    chk("t1_miso_word", mi1, 32'h3C);
    chk("t1_valid_cnt", vcnt - v0, 32'd1);
    chk("t1_irq", {31'b0, interrpt}, 32'h1);
    chk("t1_tx_empty", {31'b0, tx_empty}, 32'h1);
    chk("t1_idle_miso", {30'b0, busy, miso}, 32'h0);
    ack_clr();
    chk("t1_irq_clr", {31'b0, interrpt}, 32'h0);

    // Mode 3, 32-bit, LSB first
    set_ctrl({1'b1, MODE3, 1'b1, 2'b11, 1'b0});
    pulse_load(32'h0F0F_00FF);
    frame_start();
    xfer_word(32, 32, 32'h1234_5678, mi1);
    frame_end();
    chk("t2_rx_data", rx_data, 32'h1234_5678);
    chk("t2_miso_word", mi1, 32'h0F0F_00FF);
    ack_clr();

    // Two words under one SS with no acknowledge
    set_ctrl({1'b1, MODE0, 1'b0, 2'b00, 1'b0});
    pulse_load(32'h99);
    v0 = vcnt;
    frame_start();
    xfer_word(8, 8, 32'h11, mi1);
    xfer_word(8, 8, 32'h22, mi2);
    frame_end();
    chk("t3_rx_data", rx_data, 32'h11);
    chk("t3_overrun", {31'b0, overrun}, 32'h1);
    chk("t3_valid_cnt", vcnt - v0, 32'd1);
    chk("t3_miso_w1", mi1, 32'h99);
    chk("t3_miso_w2", mi2, 32'h00);
    ack_clr();
    chk("t3_ovr_clr", {31'b0, overrun}, 32'h0);

    // Mode 1, 16-bit, SS raised after 5 bits
    set_ctrl({1'b1, MODE1, 1'b0, 2'b01, 1'b0});
    v0 = vcnt;
    frame_start();
    xfer_word(16, 5, 32'hBEEF, mi1);
    frame_end();
    chk("t4_abort_valid", vcnt - v0, 32'd0);
    chk("t4_abort_data", rx_data, 32'h11);
    chk("t4_abort_idle", {30'b0, busy, miso}, 32'h0);
    pulse_load(32'hC3A5);
    v0 = vcnt;
    frame_start();
    xfer_word(16, 16, 32'hBEEF, mi1);
    frame_end();
    chk("t4_rx_data", rx_data, 32'hBEEF);
    chk("t4_miso_word", mi1, 32'hC3A5);
    chk("t4_valid_cnt", vcnt - v0, 32'd1);

    // Reset mid-frame after bit 3
    set_ctrl({1'b1, MODE0, 1'b0, 2'b00, 1'b0});
    frame_start();
    pulse_load(32'h77);
    chk("t5_busy", {31'b0, busy}, 32'h1);
    xfer_word(8, 3, 32'h5A, mi1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0; ss = 1'b1;
    chk("t5_rst_data", rx_data, 32'h0);
    chk("t5_rst_tx_empty", {31'b0, tx_empty}, 32'h1);
    chk("t5_rst_flags", {27'b0, miso, rx_valid, overrun, busy, interrpt}, 32'h0);
    wait_cyc(8);
    v0 = vcnt;
    frame_start();
    xfer_word(8, 8, 32'h5A, mi1);
    frame_end();
    chk("t5_rx_data", rx_data, 32'h5A);
    chk("t5_valid_cnt", vcnt - v0, 32'd1);
    ack_clr();

    // SPI_ON = 0: frame ignored, MISO held low, tx_buf retained
    set_ctrl({1'b0, MODE0, 1'b0, 2'b00, 1'b0});
    pulse_load(32'hFF);
    v0 = vcnt;
    frame_start();
    xfer_word(8, 8, 32'hFF, mi1);
    frame_end();
    chk("t6_off_valid", vcnt - v0, 32'd0);
    chk("t6_off_miso", mi1, 32'h00);
    chk("t6_off_tx_kept", {31'b0, tx_empty}, 32'h0);

    // Interrupt masked
    set_ctrl({1'b1, MODE0, 1'b0, 2'b00, 1'b1});
    v0 = vcnt;
    frame_start();
    xfer_word(8, 8, 32'h81, mi1);
    frame_end();
    chk("t6_msk_data", rx_data, 32'h81);
    chk("t6_msk_valid", vcnt - v0, 32'd1);
    chk("t6_msk_irq", {31'b0, interrpt}, 32'h0);
    chk("t6_msk_miso", mi1, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
